pic24icsp_sequencer: RTL and testbench
======================================

// Module: pic24icsp_sequencer
// PURPOSE
//  Parametrised ICSP command sequencer that replays a 28-bit script from internal instruction RAM
//  into the PIC24 serial engine (instr/cmd/valid/ready). Operands are spliced from internal data RAM.
//  Read-back words returned by the engine are counted and exported.
//  Successor to the fixed-script programmer: the script is loaded at runtime, has a start/done handshake,
//  and has a programmable length. Sits between the host/config bus and the serial engine.
// PARAMETERS
//  IMEM_AW    7   instruction RAM address width (depth 2**IMEM_AW)
//  DMEM_AW    7   data RAM address width
//  DATAWIDTH  32  data RAM word width (>=32; operand halves are [31:16] and [15:0])
// PORTS
//  clk        in   1          clock
//  rstn       in   1          asynchronous active-low reset
//  start      in   1          pulse: run script from imem[0]; ignored unless IDLE
//  prog_len   in   IMEM_AW+1  number of script words, sampled on accepted start
//  busy       out  1          high from accepted start until DONE
//  done       out  1          1-cycle pulse at script end
//  cfg_iwe    in   1          instruction RAM write strobe (ignored while busy)
//  cfg_dwe    in   1          data RAM write strobe (ignored while busy)
//  cfg_addr   in   IMEM_AW    config write address (low DMEM_AW bits used for dmem)
//  cfg_data   in   DATAWIDTH  config write data (imem uses [27:0])
//  instr      out  24         instruction to serial engine
//  cmd        out  1          0=write (SIX), 1=read (REGOUT)
//  valid      out  1          instr/cmd valid
//  ready      in   1          engine accepts; transfer = valid&ready
//  rd_valid   in   1          engine read-back word strobe
//  rd_data    in   16         engine read-back word
//  rd_count   out  IMEM_AW+1  read-back words received this run
//  mismatch   out  1          sticky verify failure (PIC24SEQ_VERIFY_EN only; else tied 0)
// BEHAVIOUR
//  Script word: [27] splice data[31:16], [26] splice data[15:0] ([27] wins),
//   [25] advance dptr after issue, [24] cmd, [23:0] instr; splice replaces instr[19:4].
//  Reset: busy=0, done=0, valid=0, instr=0, cmd=0, rd_count=0, mismatch=0, pc=0, dptr=0, state IDLE.
//  FSM: IDLE -start-> FETCH (RAM read, 1 cycle) -> ISSUE (valid=1, held stable until ready).
//   ISSUE: on transfer, pc++ and dptr++ if [25]. If pc+1==len -> DONE, else -> FETCH.
//   DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Latency: valid rises 2 cycles after accepted start; 2 cycles per word minimum (FETCH+ISSUE).
//  prog_len==0: start -> DONE next cycle; no valid; done pulses.
//  prog_len > 2**IMEM_AW: clamped to 2**IMEM_AW.
//  dptr wraps modulo 2**DMEM_AW; dptr and rd_count clear on accepted start.
//  rd_valid is counted in any state; rd_count saturates at all-ones.
//  start while busy is ignored; cfg writes while busy are dropped.
//  valid&ready in the same cycle as the last word: done follows in the next cycle.
//  Async reset mid-run: valid drops immediately; RAM contents are retained.
// CONFIGURATION
//  PIC24SEQ_VERIFY_EN defined: each rd_valid compares rd_data with the expected word, then advances a verify pointer.
//   Expected word = data RAM half at vptr: even reads use [15:0], odd reads use [31:16].
//   vptr starts at dmem[2**DMEM_AW-1] and counts down.
//   Any inequality sets mismatch (sticky until next start).
//  Undefined: no comparator and no vptr; mismatch=0.
// STRUCTURE
//  Package pic24seq_pkg: state enum (IDLE, FETCH, ISSUE, DONE), script-bit index constants
//   (SPLICE_HI=27, SPLICE_LO=26, DADV=25, CMD=24), SPLICE_MSB=19, SPLICE_LSB=4.
//  Sub-module pic24seq_ram: 1R1W synchronous RAM, parametrised width/depth; instantiated twice (imem, dmem).
// TESTING
//  1. imem={0x000000,0x040200,0x000000}, len=3, ready=1 -> 3 transfers in order, cmd=0, done 7 cycles after start.
//  2. dmem[0]=0x00FF_1234; word [27]=1 instr=0x200000 -> instr=0x200FF0; [26]=1 -> 0x212340.
//  3. ready low 5 cycles during ISSUE -> valid and instr stable; exactly one transfer counted.
//  4. len=0 -> done 1 cycle after start, valid never high; start while busy -> no restart.
//  5. Two cmd=1 words, rd_valid x2 -> rd_count=2; with VERIFY_EN and a wrong rd_data -> mismatch=1.
//  6. rstn low mid-ISSUE -> valid=0, busy=0; rerun after reset reproduces scenario 1 from the retained RAM.

Source files
------------

// File: rtl/pic24seq_pkg.sv
// Shared state encoding, script-word field positions and the operand splice
// helper for the PIC24 ICSP command sequencer.
package pic24seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int SCRIPT_W   = 28;
  localparam int SPLICE_HI  = 27;
  localparam int SPLICE_LO  = 26;
  localparam int DADV       = 25;
  localparam int CMD        = 24;
  localparam int SPLICE_MSB = 19;
  localparam int SPLICE_LSB = 4;

  // Replace the operand field of the instruction with a data half; the high half wins.
  function automatic logic [23:0] splice_instr(input logic [SCRIPT_W-1:0] word,
                                               input logic [31:0]         data);
    logic [23:0] r;
    r = word[23:0];
    if (word[SPLICE_HI]) begin
      r[SPLICE_MSB:SPLICE_LSB] = data[31:16];
    end else if (word[SPLICE_LO]) begin
      r[SPLICE_MSB:SPLICE_LSB] = data[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pic24seq_ram.sv
// Single-read single-write synchronous RAM used for the script and operand
// stores. Contents are not reset so they survive a sequencer reset.
module pic24seq_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port and registered read port share the clock.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pic24icsp_sequencer.sv
// PIC24 ICSP command sequencer: replays a runtime-loaded script from the
// instruction RAM into the serial engine, splicing operands from the data RAM,
// and counts read-back words.
// Optional build macro PIC24SEQ_VERIFY_EN adds a read-back comparator that
// checks returned words against data RAM halves walked downward from the top
// word, raising a sticky mismatch flag.
module pic24icsp_sequencer
  import pic24seq_pkg::*;
#(
  parameter int IMEM_AW   = 7,
  parameter int DMEM_AW   = 7,
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [IMEM_AW:0]     prog_len,
  output logic                 busy,
  output logic                 done,
  input  logic                 cfg_iwe,
  input  logic                 cfg_dwe,
  input  logic [IMEM_AW-1:0]   cfg_addr,
  input  logic [DATAWIDTH-1:0] cfg_data,
  output logic [23:0]          instr,
  output logic                 cmd,
  output logic                 valid,
  input  logic                 ready,
  input  logic                 rd_valid,
  input  logic [15:0]          rd_data,
  output logic [IMEM_AW:0]     rd_count,
  output logic                 mismatch
);

  localparam logic [IMEM_AW:0]   LEN_MAX = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0]   PC_ONE  = {{IMEM_AW{1'b0}}, 1'b1};
  localparam logic [DMEM_AW-1:0] DP_ONE  = {{(DMEM_AW-1){1'b0}}, 1'b1};

  seq_state_t           state;
  logic [IMEM_AW:0]     pc;
  logic [IMEM_AW:0]     pc_inc;
  logic [IMEM_AW:0]     len_q;
  logic [DMEM_AW-1:0]   dptr;
  logic                 dadv_q;
  logic [SCRIPT_W-1:0]  iword;
  logic [DATAWIDTH-1:0] dword;
  logic [IMEM_AW-1:0]   iraddr;
  logic [DMEM_AW-1:0]   draddr;
  logic                 start_ok;
  logic                 cfg_ok;

  assign start_ok = start && (state == IDLE);
  assign cfg_ok   = !busy;
  assign pc_inc   = pc + PC_ONE;

  pic24seq_ram #(.AW(IMEM_AW), .DW(SCRIPT_W)) u_imem (
    .clk   (clk),
    .we    (cfg_iwe && cfg_ok),
    .waddr (cfg_addr),
    .wdata (cfg_data[SCRIPT_W-1:0]),
    .raddr (iraddr),
    .rdata (iword)
  );

  pic24seq_ram #(.AW(DMEM_AW), .DW(DATAWIDTH)) u_dmem (
    .clk   (clk),
    .we    (cfg_dwe && cfg_ok),
    .waddr (cfg_addr[DMEM_AW-1:0]),
    .wdata (cfg_data),
    .raddr (draddr),
    .rdata (dword)
  );

  // Look one word ahead so the RAM outputs are already valid throughout FETCH.
  always_comb begin
    iraddr = '0;
    draddr = '0;
    if (state == ISSUE) begin
      iraddr = pc_inc[IMEM_AW-1:0];
      draddr = dptr + {{(DMEM_AW-1){1'b0}}, dadv_q};
    end
  end

  // Main sequencer FSM with registered engine handshake, status and read-back count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      instr    <= '0;
      cmd      <= 1'b0;
      pc       <= '0;
      len_q    <= '0;
      dptr     <= '0;
      dadv_q   <= 1'b0;
      rd_count <= '0;
    end else begin
      done <= 1'b0;
      if (rd_valid && (rd_count != '1)) begin
        rd_count <= rd_count + PC_ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            pc       <= '0;
            dptr     <= '0;
            rd_count <= '0;
            len_q    <= (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
            if (prog_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          instr  <= splice_instr(iword, dword[31:0]);
          cmd    <= iword[CMD];
          dadv_q <= iword[DADV];
          valid  <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: begin
          if (ready) begin
            valid <= 1'b0;
            pc    <= pc_inc;
            if (dadv_q) begin
              dptr <= dptr + DP_ONE;
            end
            if (pc_inc == len_q) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PIC24SEQ_VERIFY_EN
  logic [DMEM_AW-1:0]   vptr;
  logic [DMEM_AW-1:0]   vraddr;
  logic                 vodd;
  logic [DATAWIDTH-1:0] vword;
  logic [15:0]          vexp;
  logic                 unused_bits;

  assign unused_bits = ^cfg_data[DATAWIDTH-1:SCRIPT_W];

  // Shadow copy of the data RAM gives the comparator its own read port.
  pic24seq_ram #(.AW(DMEM_AW), .DW(DATAWIDTH)) u_vmem (
    .clk   (clk),
    .we    (cfg_dwe && cfg_ok),
    .waddr (cfg_addr[DMEM_AW-1:0]),
    .wdata (cfg_data),
    .raddr (vraddr),
    .rdata (vword)
  );

  // Address the word the verify pointer will hold next so vword is always current.
  always_comb begin
    vraddr = vptr;
    if (start_ok) begin
      vraddr = '1;
    end else if (rd_valid && vodd) begin
      vraddr = vptr - DP_ONE;
    end
    vexp = vodd ? vword[31:16] : vword[15:0];
  end

  // Compare each read-back half-word and walk the pointer down after the odd half.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vptr     <= '1;
      vodd     <= 1'b0;
      mismatch <= 1'b0;
    end else if (start_ok) begin
      vptr     <= '1;
      vodd     <= 1'b0;
      mismatch <= 1'b0;
    end else if (rd_valid) begin
      if (rd_data != vexp) begin
        mismatch <= 1'b1;
      end
      vodd <= !vodd;
      if (vodd) begin
        vptr <= vptr - DP_ONE;
      end
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{cfg_data[DATAWIDTH-1:SCRIPT_W], rd_data};
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_pic24icsp_sequencer.sv
// Self-checking bench for pic24icsp_sequencer: table-driven splice vectors,
// a transfer scoreboard, and hand-written multi-cycle corner cases.
module tb_pic24icsp_sequencer;

  localparam int IMEM_AW = 7;
  localparam int DMEM_AW = 7;
  localparam int DW      = 32;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [IMEM_AW:0]   prog_len;
  logic               busy;
  logic               done;
  logic               cfg_iwe;
  logic               cfg_dwe;
  logic [IMEM_AW-1:0] cfg_addr;
  logic [DW-1:0]      cfg_data;
  logic [23:0]        instr;
  logic               cmd;
  logic               valid;
  logic               ready;
  logic               rd_valid;
  logic [15:0]        rd_data;
  logic [IMEM_AW:0]   rd_count;
  logic               mismatch;

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];
  logic        valid_seen;

  always #5 clk = ~clk;

  pic24icsp_sequencer #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .DATAWIDTH(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .prog_len (prog_len),
    .busy     (busy),
    .done     (done),
    .cfg_iwe  (cfg_iwe),
    .cfg_dwe  (cfg_dwe),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .instr    (instr),
    .cmd      (cmd),
    .valid    (valid),
    .ready    (ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_count (rd_count),
    .mismatch (mismatch)
  );

  // Record every engine transfer half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (rstn && valid && ready) got_q.push_back({cmd, instr});
    if (valid) valid_seen = 1'b1;
  end

  typedef struct {
    logic [27:0] word;
    logic [31:0] data;
    logic [23:0] exp_instr;
    logic        exp_cmd;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic to_imem, input int addr, input logic [31:0] data);
    cfg_iwe  = to_imem;
    cfg_dwe  = !to_imem;
    cfg_addr = addr[IMEM_AW-1:0];
    cfg_data = data;
    tick();
    cfg_iwe  = 1'b0;
    cfg_dwe  = 1'b0;
  endtask

  task automatic applyStimulus(input int len);
    prog_len = len[IMEM_AW:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitDone(inout int cyc);
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pushExp(input logic c, input logic [23:0] i);
    exp_q.push_back({c, i});
  endtask

  task automatic loadProg1();
    cfgWrite(1'b1, 0, 32'h0000000);
    cfgWrite(1'b1, 1, 32'h0040200);
    cfgWrite(1'b1, 2, 32'h0000000);
  endtask

  task automatic pushProg1();
    pushExp(1'b0, 24'h000000);
    pushExp(1'b0, 24'h040200);
    pushExp(1'b0, 24'h000000);
  endtask

  task automatic compareScoreboard(input string tag);
    logic [24:0] e;
    logic [24:0] a;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 25'h1FFFFFF;
      checkOutput($sformatf("%s_xfer%0d", tag, n), {7'd0, a}, {7'd0, e});
      n++;
    end
    checkOutput($sformatf("%s_extra_xfers", tag), got_q.size(), 0);
    got_q.delete();
  endtask

  initial begin
    int cyc;
    int k;
    logic stable;
    logic [23:0] held;

    vecs[0] = '{word: 28'h8200000, data: 32'h00FF1234, exp_instr: 24'h200FF0, exp_cmd: 1'b0};
    vecs[1] = '{word: 28'h4200000, data: 32'h00FF1234, exp_instr: 24'h212340, exp_cmd: 1'b0};
    vecs[2] = '{word: 28'hC200000, data: 32'h00FF1234, exp_instr: 24'h200FF0, exp_cmd: 1'b0};
    vecs[3] = '{word: 28'h1ABCDEF, data: 32'h5555AAAA, exp_instr: 24'hABCDEF, exp_cmd: 1'b1};
    vecs[4] = '{word: 28'h9FFFFFF, data: 32'h00FF1234, exp_instr: 24'hF00FFF, exp_cmd: 1'b1};
    vecs[5] = '{word: 28'h4000000, data: 32'hABCD1234, exp_instr: 24'h012340, exp_cmd: 1'b0};

    start = 0; prog_len = '0; cfg_iwe = 0; cfg_dwe = 0; cfg_addr = '0; cfg_data = '0;
    ready = 1; rd_valid = 0; rd_data = '0; valid_seen = 0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_instr", instr, 0);
    checkOutput("reset_rd_count", rd_count, 0);
    checkOutput("reset_mismatch", mismatch, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // Scenario 1: three plain words, latency and ordering
    $display("[TB] scenario 1: basic replay");
    loadProg1();
    pushProg1();
    applyStimulus(3);
    checkOutput("s1_busy_after_start", busy, 1);
    checkOutput("s1_valid_in_fetch", valid, 0);
    tick();
    checkOutput("s1_valid_rise", valid, 1);
    cyc = 2;
    waitDone(cyc);
    checkOutput("s1_done_latency", cyc, 7);
    checkOutput("s1_busy_at_done", busy, 0);
    tick();
    checkOutput("s1_done_one_cycle", done, 0);
    compareScoreboard("s1");

    // Scenario 2: splice vectors, one word each
    $display("[TB] scenario 2: splice table");
    for (int i = 0; i < 6; i++) begin
      cfgWrite(1'b1, 0, {4'h0, vecs[i].word});
      cfgWrite(1'b0, 0, vecs[i].data);
      pushExp(vecs[i].exp_cmd, vecs[i].exp_instr);
      applyStimulus(1);
      cyc = 1;
      waitDone(cyc);
      checkOutput($sformatf("s2_v%0d_done_latency", i), cyc, 3);
      tick();
      compareScoreboard($sformatf("s2_v%0d", i));
    end

    // Scenario 2b: data pointer advance
    $display("[TB] scenario 2b: dptr advance");
    cfgWrite(1'b1, 0, 32'h6000000);
    cfgWrite(1'b1, 1, 32'h4000000);
    cfgWrite(1'b1, 2, 32'h4000000);
    cfgWrite(1'b0, 0, 32'h00001111);
    cfgWrite(1'b0, 1, 32'h00002222);
    pushExp(1'b0, 24'h011110);
    pushExp(1'b0, 24'h022220);
    pushExp(1'b0, 24'h022220);
    applyStimulus(3);
    cyc = 1;
    waitDone(cyc);
    tick();
    compareScoreboard("s2b");

    // Scenario 3: back-pressure holds the word stable
    $display("[TB] scenario 3: ready low");
    cfgWrite(1'b1, 0, 32'h0123456);
    ready = 1'b0;
    pushExp(1'b0, 24'h123456);
    applyStimulus(1);
    k = 0;
    while (!valid && k < 20) begin tick(); k++; end
    checkOutput("s3_valid_seen", valid, 1);
    held = instr;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!valid || instr !== held) stable = 1'b0;
    end
    checkOutput("s3_hold_stable", stable, 1);
    ready = 1'b1;
    cyc = 1;
    waitDone(cyc);
    checkOutput("s3_done_seen", done, 1);
    tick();
    compareScoreboard("s3");

    // Scenario 4: empty script, then start and cfg write while busy
    $display("[TB] scenario 4: len 0 and busy protection");
    valid_seen = 1'b0;
    applyStimulus(0);
    checkOutput("s4_len0_done", done, 1);
    tick();
    tick();
    checkOutput("s4_len0_no_valid", valid_seen, 0);
    loadProg1();
    pushProg1();
    applyStimulus(3);
    cyc = 1;
    repeat (2) begin tick(); cyc++; end
    prog_len = 8'd1;
    start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    cfgWrite(1'b1, 1, 32'h0FFFFFF); cyc++;
    waitDone(cyc);
    checkOutput("s4_busy_no_restart_latency", cyc, 7);
    tick();
    compareScoreboard("s4");
    pushProg1();
    applyStimulus(3);
    cyc = 1;
    waitDone(cyc);
    tick();
    compareScoreboard("s4_cfg_dropped");

    // Scenario 4b: length above RAM depth is clamped
    $display("[TB] scenario 4b: length clamp");
    applyStimulus(200);
    cyc = 1;
    waitDone(cyc);
    checkOutput("s4b_clamp_latency", cyc, 257);
    tick();
    checkOutput("s4b_clamp_xfers", got_q.size(), 128);
    got_q.delete();

    // Scenario 5: read-back counting and verify
    $display("[TB] scenario 5: read-back");
    cfgWrite(1'b1, 0, 32'h1000001);
    cfgWrite(1'b1, 1, 32'h1000002);
    cfgWrite(1'b0, 127, 32'hBEEFCAFE);
    pushExp(1'b1, 24'h000001);
    pushExp(1'b1, 24'h000002);
    applyStimulus(2);
    rd_data = 16'hCAFE;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    checkOutput("s5_mismatch_after_good", mismatch, 0);
    rd_data = 16'hDEAD;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    checkOutput("s5_rd_count", rd_count, 2);
    cyc = 3;
    waitDone(cyc);
    tick();
`ifdef PIC24SEQ_VERIFY_EN
    checkOutput("s5_mismatch_sticky", mismatch, 1);
`else
    checkOutput("s5_mismatch_tied", mismatch, 0);
`endif
    compareScoreboard("s5");
    applyStimulus(0);
    checkOutput("s5_rd_count_clear", rd_count, 0);
    checkOutput("s5_mismatch_clear", mismatch, 0);
    tick();

    // Scenario 6: asynchronous reset mid-issue, then rerun from retained RAM
    $display("[TB] scenario 6: reset mid-run");
    loadProg1();
    ready = 1'b0;
    applyStimulus(3);
    k = 0;
    while (!valid && k < 20) begin tick(); k++; end
    checkOutput("s6_in_issue", valid, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("s6_valid_drop", valid, 0);
    checkOutput("s6_busy_drop", busy, 0);
    tick();
    rstn = 1'b1;
    ready = 1'b1;
    got_q.delete();
    tick();
    pushProg1();
    applyStimulus(3);
    cyc = 1;
    waitDone(cyc);
    checkOutput("s6_rerun_latency", cyc, 7);
    tick();
    compareScoreboard("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
